// File: rtl/varredura_mapa_pkg.sv
// Shared constants, cursor struct and column decode for the LED matrix scanner.
package varredura_mapa_pkg;

  localparam int NUM_COLUNAS = 5;
  localparam int NUM_LINHAS  = 7;

  localparam logic [NUM_COLUNAS-1:0] COLUNAS_OFF = 5'b11111;

  // Cursor position and enable as captured once per frame.
  typedef struct packed {
    logic       en;
    logic [2:0] x;
    logic [2:0] y;
  } cursor_t;

  // One-hot active-low column select for column c (0..4).
  function automatic logic [NUM_COLUNAS-1:0] coluna_onehot(input logic [2:0] c);
    logic [NUM_COLUNAS-1:0] um;
    um = 5'b00001;
    return ~(um << c);
  endfunction

endpackage

// File: rtl/varredura_mapa_if.sv
// Map/cursor inputs and matrix drive outputs of the scanner.
interface varredura_mapa_if;
  import varredura_mapa_pkg::*;

  logic [NUM_LINHAS-1:0]  mapa0;
  logic [NUM_LINHAS-1:0]  mapa1;
  logic [NUM_LINHAS-1:0]  mapa2;
  logic [NUM_LINHAS-1:0]  mapa3;
  logic [NUM_LINHAS-1:0]  mapa4;
  logic                   cursor_en;
  logic [2:0]             cursor_x;
  logic [2:0]             cursor_y;
  logic [NUM_COLUNAS-1:0] colunas;
  logic [NUM_LINHAS-1:0]  linhas;
  logic                   frame_start;

  // Source of map words and cursor; sink of the matrix drive.
  modport master (
    output mapa0, mapa1, mapa2, mapa3, mapa4,
    output cursor_en, cursor_x, cursor_y,
    input  colunas, linhas, frame_start
  );

  // The scanner itself.
  modport slave (
    input  mapa0, mapa1, mapa2, mapa3, mapa4,
    input  cursor_en, cursor_x, cursor_y,
    output colunas, linhas, frame_start
  );
endinterface

// File: rtl/varredura_mapa_contador.sv
// Column-period divider and column counter for the matrix scan.
module contador_varredura #(
  parameter int DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [2:0] col,
  output logic       blank,
  output logic       fim_frame
);
  localparam int             DW     = $clog2(DIV);
  localparam logic [DW-1:0]  ULTIMO = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // div_cnt runs 0..DIV-1 per column; col steps 0..4 on each wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      col     <= '0;
    end else if (en) begin
      if (div_cnt == ULTIMO) begin
        div_cnt <= '0;
        col     <= (col == 3'd4) ? 3'd0 : col + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Blank is the first cycle of every column; fim_frame the last cycle of column 4.
  always_comb begin
    blank     = (div_cnt == '0);
    fim_frame = (col == 3'd4) && (div_cnt == ULTIMO);
  end

endmodule

// File: rtl/varredura_mapa.sv
// 5x7 LED matrix scanner: per-frame snapshot, blink timing and cursor overlay.
module varredura_mapa
  import varredura_mapa_pkg::*;
#(
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic               clk,
  input  logic               reset,
  varredura_mapa_if.slave    bus
);
  localparam int                FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0]     FRAME_ULT = FW'(BLINK_FRAMES - 1);

  logic [2:0]  col;
  logic        blank;
  logic        fim_frame;

  // em_reset marks the cycle right after a reset edge: counters hold so the
  // first cycle after release is the column-0 blank cycle.
  logic        em_reset;
  logic        fs_q;
  logic [FW-1:0] frame_cnt;
  logic        blink;
  logic        blink_q;
  cursor_t     cur;
  logic [NUM_COLUNAS-1:0][NUM_LINHAS-1:0] buffer;
  logic [NUM_LINHAS-1:0] linhas_drv;

  contador_varredura #(.DIV(DIV)) u_cont (
    .clk       (clk),
    .reset     (reset),
    .en        (~em_reset),
    .col       (col),
    .blank     (blank),
    .fim_frame (fim_frame)
  );

  // Reset tracking and registered frame_start (high during the column-0 blank cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      em_reset <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      em_reset <= 1'b0;
      fs_q     <= em_reset || fim_frame;
    end
  end

  // At the edge ending the column-0 blank cycle: snapshot map/cursor, advance blink.
  // The overlay uses the blink phase captured with the snapshot, so a toggle
  // shows from the following frame on.
  always_ff @(posedge clk) begin
    if (reset) begin
      buffer    <= '0;
      cur       <= '0;
      frame_cnt <= '0;
      blink     <= 1'b0;
      blink_q   <= 1'b0;
    end else if (fs_q) begin
      buffer  <= {bus.mapa4, bus.mapa3, bus.mapa2, bus.mapa1, bus.mapa0};
      cur     <= '{en: bus.cursor_en, x: bus.cursor_x, y: bus.cursor_y};
      blink_q <= blink;
      if (frame_cnt == FRAME_ULT) begin
        frame_cnt <= '0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Row data with optional cursor pixel inversion; out-of-range cursor ignored.
  always_comb begin
    linhas_drv = buffer[col];
    if (cur.en && (cur.x <= 3'd4) && (cur.y <= 3'd6) && (cur.x == col))
      linhas_drv[cur.y] = linhas_drv[cur.y] ^ blink_q;
  end

  // Output decode from registers only: blank cycle turns everything off.
  always_comb begin
    bus.colunas     = blank ? COLUNAS_OFF : coluna_onehot(col);
    bus.linhas      = blank ? '0 : linhas_drv;
    bus.frame_start = fs_q;
  end

endmodule

// File: tb/tb_varredura_mapa.sv
// Directed bench for varredura_mapa with DIV=4, BLINK_FRAMES=2.
module tb_varredura_mapa;
  logic clk;
  logic reset;
  int   total;
  int   passed;

  varredura_mapa_if bus();

  varredura_mapa #(.DIV(4), .BLINK_FRAMES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [6:0] obs, input logic [6:0] esp);
    total++;
    assert (obs === esp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, esp);
  endtask

  task automatic ciclo_chk(input string tag, input logic [4:0] ecol,
                           input logic [6:0] elin, input logic efs);
    verifica({tag, " colunas"}, {2'b00, bus.colunas}, {2'b00, ecol});
    verifica({tag, " linhas"}, bus.linhas, elin);
    verifica({tag, " frame_start"}, {6'd0, bus.frame_start}, {6'd0, efs});
  endtask

  task automatic set_mapa(input logic [4:0][6:0] m);
    bus.mapa0 = m[0];
    bus.mapa1 = m[1];
    bus.mapa2 = m[2];
    bus.mapa3 = m[3];
    bus.mapa4 = m[4];
  endtask

  // One 20-cycle frame: blank then 3 driven cycles per column.
  // Optionally changes mapa2 right after frame cycle troca_em.
  task automatic verifica_frame(input string tag, input logic [4:0][6:0] esp,
                                input int troca_em, input logic [6:0] novo_m2);
    logic [4:0] um;
    logic [4:0] ecol;
    logic [6:0] elin;
    int k;
    int d;
    um = 5'b00001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      k = c / 4;
      d = c % 4;
      ecol = (d == 0) ? 5'b11111 : ~(um << k);
      elin = (d == 0) ? 7'd0 : esp[k];
      ciclo_chk($sformatf("%s c%0d", tag, c), ecol, elin, c == 0);
      if (c == troca_em) bus.mapa2 = novo_m2;
    end
  endtask

  task automatic pulso_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    ciclo_chk(tag, 5'b11111, 7'd0, 1'b0);
    reset = 1'b0;
  endtask

  logic [4:0][6:0] base;
  logic [4:0][6:0] novo;
  logic [4:0][6:0] inv;

  initial begin
    total  = 0;
    passed = 0;
    base = {7'b1000011, 7'b1110001, 7'b1000101, 7'b0001100, 7'b0000100};
    novo = base;
    novo[2] = 7'b1111111;
    inv = base;
    inv[2] = 7'b1000100;

    reset = 1'b1;
    set_mapa(base);
    bus.cursor_en = 1'b0;
    bus.cursor_x  = 3'd0;
    bus.cursor_y  = 3'd0;

    // Reset held 3 cycles: all off, no frame_start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ciclo_chk($sformatf("rst%0d", i), 5'b11111, 7'd0, 1'b0);
    end
    reset = 1'b0;

    // Scan order, with mapa2 changed during column 1 (snapshot isolation).
    verifica_frame("scan f0", base, 6, 7'b1111111);
    verifica_frame("scan f1", novo, -1, 7'd0);

    // Blinking cursor at (2,0).
    set_mapa(base);
    bus.cursor_en = 1'b1;
    bus.cursor_x  = 3'd2;
    bus.cursor_y  = 3'd0;
    pulso_reset("rst blink");
    verifica_frame("blink f0", base, -1, 7'd0);
    verifica_frame("blink f1", base, -1, 7'd0);
    verifica_frame("blink f2", inv, -1, 7'd0);
    verifica_frame("blink f3", inv, -1, 7'd0);
    verifica_frame("blink f4", base, -1, 7'd0);
    verifica_frame("blink f5", base, -1, 7'd0);

    // Out-of-range cursor x.
    bus.cursor_x = 3'd5;
    bus.cursor_y = 3'd0;
    pulso_reset("rst x5");
    for (int f = 0; f < 4; f++) verifica_frame($sformatf("x5 f%0d", f), base, -1, 7'd0);

    // Out-of-range cursor y.
    bus.cursor_x = 3'd2;
    bus.cursor_y = 3'd7;
    pulso_reset("rst y7");
    for (int f = 0; f < 4; f++) verifica_frame($sformatf("y7 f%0d", f), base, -1, 7'd0);

    // Reset mid-frame during column 3 of frame 2; blink phase must restart.
    bus.cursor_y = 3'd0;
    pulso_reset("rst mid pre");
    verifica_frame("mid f0", base, -1, 7'd0);
    verifica_frame("mid f1", base, -1, 7'd0);
    repeat (13) @(negedge clk);
    pulso_reset("rst mid");
    verifica_frame("post f0", base, -1, 7'd0);
    verifica_frame("post f1", base, -1, 7'd0);
    verifica_frame("post f2", inv, -1, 7'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
